uart_fifo_param: RTL and testbench
==================================

UART_FIFO_PARAM -- requirements
Module: uart_fifo_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, reset baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8.
REQ-004 SHALL have parameter PARITY, default 0, where 0=none, 1=odd, 2=even.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, power of two, minimum 2; applies to each of TX and RX.
REQ-007 SHALL have ports: sys_clk in 1, the single clock; sys_rst_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: uart_rx in 1, serial input, asynchronous; uart_tx out 1, serial output.
REQ-009 SHALL have ports: divisor_in in 16, new 16x-oversample divisor; divisor_wr in 1, load strobe.
REQ-010 SHALL have ports: tx_data in 8, byte to send (upper bits ignored when DATA_BITS<8); tx_wr in 1, push strobe; tx_full out 1, TX FIFO full; tx_irq out 1, one-cycle pulse when the last queued frame's final stop bit completes.
REQ-011 SHALL have ports: rx_data out 8, head byte, zero-extended; rx_perr out 1, head parity error; rx_ferr out 1, head framing error; rx_empty out 1, RX FIFO empty; rx_rd in 1, pop strobe; rx_irq out 1, one-cycle pulse per byte pushed; rx_overrun out 1, sticky; err_clr in 1, clears rx_overrun.

Function
REQ-012 Baud tick SHALL be a 16-bit down-counter reloaded with the current divisor, issuing a one-cycle tick at 16x baud; divisor value 0 SHALL be treated as 1.
REQ-013 divisor_wr SHALL latch divisor_in and restart the tick counter on the next cycle; frames in flight continue at the new rate.
REQ-014 TX SHALL run IDLE -> START -> DATA -> PARITY (only when PARITY!=0) -> STOP -> IDLE; each bit lasts 16 ticks; LSB first; STOP lasts 16*STOP_BITS ticks.
REQ-015 In TX IDLE with TX FIFO non-empty, TX SHALL pop the head byte and enter START on the next tick boundary; back-to-back frames SHALL have no idle gap.
REQ-016 Parity bit SHALL be XOR of the DATA_BITS data bits for even, its inverse for odd.
REQ-017 tx_wr while tx_full SHALL be ignored with FIFO contents unchanged; simultaneous push and pop when full SHALL be accepted.
REQ-018 uart_rx SHALL pass a two-flop synchronizer before use.
REQ-019 RX SHALL run IDLE -> START -> DATA -> PARITY (only when PARITY!=0) -> STOP -> IDLE.
REQ-020 RX SHALL leave IDLE on a synchronized falling edge and sample mid-bit at tick 8 of START; if the line is high there, RX SHALL return to IDLE with no push (false start).
REQ-021 RX SHALL sample subsequent bits every 16 ticks; only the first stop bit is checked.
REQ-022 At the stop sample, RX SHALL push {ferr, perr, data} regardless of errors; ferr=1 when stop bit is 0, perr=1 on parity mismatch.
REQ-023 If the RX FIFO is full at push time, RX SHALL drop the byte, set rx_overrun and not pulse rx_irq; a same-cycle rx_rd SHALL free space so the push succeeds.
REQ-024 The RX FIFO SHALL be show-ahead: rx_data/rx_perr/rx_ferr valid whenever rx_empty=0; rx_rd while empty SHALL be ignored.
REQ-025 err_clr coinciding with a new overrun SHALL leave rx_overrun set.

Reset
REQ-026 While sys_rst_n=0, SHALL hold: uart_tx=1, tx_full=0, tx_irq=0, rx_empty=1, rx_data=0, rx_perr=0, rx_ferr=0, rx_irq=0, rx_overrun=0.
REQ-027 Reset SHALL return both state machines to IDLE, empty both FIFOs, set divisor to CLK_FREQ/BAUD/16 (54 at defaults), and load synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL abort the frame immediately with no partial push; after release, RX SHALL wait for a fresh falling edge.

Structure
REQ-029 Package uart_pkg SHALL hold the parity encodings (PAR_NONE/ODD/EVEN), TX/RX state encodings and the default-divisor function.
REQ-030 Sub-module uart_sync_fifo SHALL be instantiated twice (TX 8-bit wide, RX 10-bit wide), each parametrised by width and depth, with full/empty derived from pointers carrying one extra wrap bit.

Verification (divisor forced to 4 unless stated)
REQ-031 Push 0xA5, 8N1 -> uart_tx shows 0,1,0,1,0,0,1,0,1,1 at 64 cycles per bit; one tx_irq pulse.
REQ-032 Loopback uart_tx->uart_rx, PARITY=2, push 0x00,0xFF,0x3C -> same three bytes read, perr=ferr=0, three rx_irq pulses.
REQ-033 Drive frame 0x55 with stop bit 0, then frame 0x81 with wrong parity (PARITY=1) -> ferr=1 on first head, perr=1 on second head.
REQ-034 FIFO_DEPTH=4, receive 5 bytes without rx_rd -> bytes 1-4 retained, rx_overrun=1, fifth dropped; err_clr -> rx_overrun=0.
REQ-035 Low glitch of 3 ticks on uart_rx -> no push; reset asserted mid-TX frame -> uart_tx=1 and both FIFOs empty within one cycle.
REQ-036 Load divisor 2 via divisor_wr, send 0x5A -> bit period 32 cycles; after reset, bit period returns to 864 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the parametrised UART with TX/RX FIFOs.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    // A zero divisor would stall the tick generator, so it behaves as 1.
    function automatic logic [15:0] div_eff(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

    function automatic logic [15:0] default_divisor(input int clk_freq, input int baud);
        return 16'(clk_freq / baud / 16);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO, show-ahead read; pointers carry an extra wrap bit for full/empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_rd   = rd_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_wr   = wr_i && (!full_o || do_rd);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_fifo_param.sv
// UART transceiver with programmable 16x-oversample divisor and TX/RX FIFOs.
module uart_fifo_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        uart_rx,
    output logic        uart_tx,
    input  logic [15:0] divisor_in,
    input  logic        divisor_wr,
    input  logic [7:0]  tx_data,
    input  logic        tx_wr,
    output logic        tx_full,
    output logic        tx_irq,
    output logic [7:0]  rx_data,
    output logic        rx_perr,
    output logic        rx_ferr,
    output logic        rx_empty,
    input  logic        rx_rd,
    output logic        rx_irq,
    output logic        rx_overrun,
    input  logic        err_clr
);
    localparam logic [15:0] DIV_RST = default_divisor(CLK_FREQ, BAUD);
    localparam logic [7:0]  DMASK   = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]  DLAST   = 3'(DATA_BITS - 1);
    localparam logic [2:0]  SLAST   = 3'(STOP_BITS - 1);
    localparam logic        PAR_INV = (PARITY == PAR_ODD);

    logic [15:0] div_q, cnt_q;
    logic        tick;

    assign tick = (cnt_q == 16'd0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q <= DIV_RST;
            cnt_q <= div_eff(DIV_RST) - 16'd1;
        end else if (divisor_wr) begin
            div_q <= divisor_in;
            cnt_q <= div_eff(divisor_in) - 16'd1;
        end else if (tick) begin
            cnt_q <= div_eff(div_q) - 16'd1;
        end else begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    tx_state_e  tx_state_q, tx_state_d;
    logic [3:0] tx_tick_q, tx_tick_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_sh_q, tx_sh_d, tx_head;
    logic       tx_par_q, tx_par_d, tx_line_q, tx_line_d;
    logic       tx_pop, tx_done, tx_empty, tx_bit_end, tx_irq_q;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(sys_clk), .rst_n(sys_rst_n), .wr_i(tx_wr), .wdata_i(tx_data),
        .rd_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    assign tx_bit_end = tick && (tx_tick_q == 4'd15);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_done    = 1'b0;
        if (tick && tx_state_q != TX_IDLE) tx_tick_d = tx_tick_q + 4'd1;
        case (tx_state_q)
            TX_IDLE:   if (tick && !tx_empty) tx_pop = 1'b1;
            TX_START:  if (tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = 3'd0;
            end
            TX_DATA:   if (tx_bit_end) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == DLAST) begin
                    tx_state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                    tx_bit_d   = 3'd0;
                end
            end
            TX_PARITY: if (tx_bit_end) begin
                tx_state_d = TX_STOP;
                tx_bit_d   = 3'd0;
            end
            TX_STOP:   if (tx_bit_end) begin
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == SLAST) begin
                    tx_state_d = TX_IDLE;
                    // Chain straight into the next frame so there is no idle gap.
                    if (!tx_empty) tx_pop = 1'b1;
                    else           tx_done = 1'b1;
                end
            end
            default:   tx_state_d = TX_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_d = TX_START;
            tx_tick_d  = 4'd0;
            tx_sh_d    = tx_head & DMASK;
            tx_par_d   = (^(tx_head & DMASK)) ^ PAR_INV;
        end
    end

    always_comb begin
        tx_line_d = 1'b1;
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_sh_d[0];
            TX_PARITY: tx_line_d = tx_par_d;
            default:   tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'd0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_irq_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            tx_irq_q   <= tx_done;
        end
    end

    assign uart_tx = tx_line_q;
    assign tx_irq  = tx_irq_q;

    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_tick_q, rx_tick_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic       rx_s1_q, rx_s2_q, rx_prev_q, rx_perr_q, rx_perr_d;
    logic       rx_sample, rx_push, rx_full, rx_ovf, rx_irq_q, rx_ovr_q;
    logic [9:0] rx_head;

    // START samples at its 8th tick (mid-bit); every later bit is 16 ticks on.
    assign rx_sample = tick && (rx_tick_q == ((rx_state_q == RX_START) ? 4'd7 : 4'd15));

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_perr_d  = rx_perr_q;
        rx_push    = 1'b0;
        if (tick) rx_tick_d = rx_tick_q + 4'd1;
        case (rx_state_q)
            RX_IDLE: begin
                rx_tick_d = 4'd0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
            end
            RX_START:  if (rx_sample) begin
                rx_tick_d = 4'd0;
                if (rx_s2_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = 3'd0;
                    rx_sh_d    = 8'd0;
                    rx_perr_d  = 1'b0;
                end
            end
            RX_DATA:   if (rx_sample) begin
                rx_sh_d[rx_bit_q] = rx_s2_q;
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == DLAST)
                    rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_sample) begin
                rx_perr_d  = rx_s2_q != ((^rx_sh_q) ^ PAR_INV);
                rx_state_d = RX_STOP;
            end
            RX_STOP:   if (rx_sample) begin
                rx_push    = 1'b1;
                rx_state_d = RX_IDLE;
            end
            default:   rx_state_d = RX_IDLE;
        endcase
    end

    uart_sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(sys_clk), .rst_n(sys_rst_n), .wr_i(rx_push), .wdata_i({!rx_s2_q, rx_perr_q, rx_sh_q}),
        .rd_i(rx_rd), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );

    assign rx_ovf = rx_push && rx_full && !rx_rd;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_perr_q  <= 1'b0;
            rx_irq_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_perr_q  <= rx_perr_d;
            rx_irq_q   <= rx_push && !rx_ovf;
            if (rx_ovf)       rx_ovr_q <= 1'b1;
            else if (err_clr) rx_ovr_q <= 1'b0;
        end
    end

    assign rx_data    = rx_head[7:0];
    assign rx_perr    = rx_head[8];
    assign rx_ferr    = rx_head[9];
    assign rx_irq     = rx_irq_q;
    assign rx_overrun = rx_ovr_q;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Randomised bench for uart_fifo_param: frame-level line model plus a queue scoreboard for RX.
module tb_uart_fifo_param;
    localparam int CLK_FREQ   = 100000000;
    localparam int BAUD       = 115200;
    localparam int DATA_BITS  = 8;
    localparam int PARITY     = 2;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int FLEN       = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        uart_rx, uart_tx;
    logic [15:0] divisor_in = 16'd0;
    logic        divisor_wr = 1'b0;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_wr = 1'b0, tx_full, tx_irq;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_empty, rx_irq, rx_overrun;
    logic        rx_rd = 1'b0, err_clr = 1'b0;
    logic        rx_drv = 1'b1, loop_en = 1'b0;

    int n_cmp = 0, n_mis = 0;
    int tx_irq_cnt = 0, rx_irq_cnt = 0;
    logic [9:0] exp_q[$];
    int exp_push = 0;
    bit exp_ovr = 0;

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    uart_fifo_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
        .PARITY(PARITY), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .divisor_in(divisor_in), .divisor_wr(divisor_wr),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_irq(tx_irq),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_empty(rx_empty),
        .rx_rd(rx_rd), .rx_irq(rx_irq), .rx_overrun(rx_overrun), .err_clr(err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (tx_irq === 1'b1) tx_irq_cnt++;
        if (rx_irq === 1'b1) rx_irq_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line level of frame bit i: start, data LSB first, parity, stop bits.
    function automatic logic ref_bit(input logic [7:0] b, input int i);
        int ones = 0;
        for (int k = 0; k < DATA_BITS; k++) ones += (b >> k) & 1;
        if (i == 0) return 1'b0;
        if (i <= DATA_BITS) return logic'((b >> (i - 1)) & 1);
        if (PARITY != 0 && i == DATA_BITS + 1)
            return (PARITY == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
        return 1'b1;
    endfunction

    task automatic model_rx(input logic [7:0] b, input logic perr, input logic ferr);
        if (exp_q.size() < FIFO_DEPTH) begin
            exp_q.push_back({ferr, perr, b});
            exp_push++;
        end else begin
            exp_ovr = 1;
        end
    endtask

    task automatic set_div(input logic [15:0] d);
        @(negedge sys_clk) divisor_in = d; divisor_wr = 1'b1;
        @(negedge sys_clk) divisor_wr = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge sys_clk) tx_data = b; tx_wr = 1'b1;
        @(negedge sys_clk) tx_wr = 1'b0;
    endtask

    task automatic wait_fall(input int limit, output bit ok);
        ok = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge sys_clk);
            if (uart_tx == 1'b0) begin ok = 1; break; end
        end
    endtask

    task automatic check_tx_frame(input string tag, input logic [7:0] b, input int bp);
        bit ok;
        wait_fall(4 * bp, ok);
        check_eq({tag, "_start_seen"}, ok, 1'b1);
        if (ok) begin
            repeat (bp / 2) @(negedge sys_clk);
            for (int i = 0; i < FLEN; i++) begin
                check_eq($sformatf("%s_bit%0d", tag, i), uart_tx, ref_bit(b, i));
                if (i < FLEN - 1) repeat (bp) @(negedge sys_clk);
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic par_flip, input logic stop_val, input int bp);
        logic v;
        for (int i = 0; i < FLEN; i++) begin
            v = ref_bit(b, i);
            if (PARITY != 0 && i == DATA_BITS + 1) v = v ^ par_flip;
            if (i == FLEN - STOP_BITS) v = stop_val;
            rx_drv = v;
            repeat (bp) @(negedge sys_clk);
        end
        rx_drv = 1'b1;
        repeat (bp) @(negedge sys_clk);
        model_rx(b, par_flip, ~stop_val);
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] e;
        e = exp_q.pop_front();
        @(negedge sys_clk);
        check_eq({tag, "_empty"}, rx_empty, 1'b0);
        check_eq({tag, "_data"}, rx_data, e[7:0]);
        check_eq({tag, "_perr"}, rx_perr, e[8]);
        check_eq({tag, "_ferr"}, rx_ferr, e[9]);
        rx_rd = 1'b1;
        @(negedge sys_clk) rx_rd = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] lb [4];
        int irq0, push0, cnt;
        bit ok;

        repeat (3) @(negedge sys_clk);
        check_eq("rst_uart_tx", uart_tx, 1'b1);
        check_eq("rst_tx_full", tx_full, 1'b0);
        check_eq("rst_tx_irq", tx_irq, 1'b0);
        check_eq("rst_rx_empty", rx_empty, 1'b1);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_rx_perr", rx_perr, 1'b0);
        check_eq("rst_rx_ferr", rx_ferr, 1'b0);
        check_eq("rst_rx_irq", rx_irq, 1'b0);
        check_eq("rst_rx_overrun", rx_overrun, 1'b0);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        set_div(16'd4);

        // Transmit: directed 0xA5 then random bytes, one irq each.
        for (int n = 0; n < 4; n++) begin
            b = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            irq0 = tx_irq_cnt;
            push_tx(b);
            check_tx_frame($sformatf("tx%0d", n), b, 64);
            repeat (64) @(negedge sys_clk);
            check_eq($sformatf("tx%0d_irq", n), tx_irq_cnt - irq0, 1);
        end

        // Loopback: TX feeds RX, four queued bytes.
        loop_en = 1'b1;
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C; lb[3] = 8'($urandom_range(0, 255));
        irq0 = rx_irq_cnt;
        push0 = exp_push;
        for (int n = 0; n < 4; n++) begin
            push_tx(lb[n]);
            model_rx(lb[n], 1'b0, 1'b0);
        end
        for (int c = 0; c < 6000 && (rx_irq_cnt - irq0) < 4; c++) @(negedge sys_clk);
        repeat (100) @(negedge sys_clk);
        check_eq("loop_rx_irq", rx_irq_cnt - irq0, exp_push - push0);
        check_eq("loop_overrun", rx_overrun, exp_ovr);
        for (int n = 0; n < 4; n++) pop_check($sformatf("loop%0d", n));
        check_eq("loop_drained", rx_empty, 1'b1);
        loop_en = 1'b0;

        // Framing error then parity error.
        send_rx(8'h55, 1'b0, 1'b0, 64);
        send_rx(8'h81, 1'b1, 1'b1, 64);
        pop_check("ferr_frame");
        pop_check("perr_frame");

        // Overrun: five frames into a four-deep FIFO with no reads.
        irq0 = rx_irq_cnt;
        push0 = exp_push;
        for (int n = 0; n < 5; n++) send_rx(8'($urandom_range(0, 255)), 1'b0, 1'b1, 64);
        check_eq("ovr_set", rx_overrun, exp_ovr);
        check_eq("ovr_rx_irq", rx_irq_cnt - irq0, exp_push - push0);
        @(negedge sys_clk) err_clr = 1'b1;
        @(negedge sys_clk) err_clr = 1'b0;
        exp_ovr = 0;
        check_eq("ovr_clr", rx_overrun, exp_ovr);
        for (int n = 0; n < 4; n++) pop_check($sformatf("ovr%0d", n));
        check_eq("ovr_drained", rx_empty, 1'b1);

        // Short low glitch is a false start.
        irq0 = rx_irq_cnt;
        rx_drv = 1'b0;
        repeat (12) @(negedge sys_clk);
        rx_drv = 1'b1;
        repeat (1200) @(negedge sys_clk);
        check_eq("glitch_empty", rx_empty, 1'b1);
        check_eq("glitch_irq", rx_irq_cnt - irq0, 0);

        // Reset mid-TX with a byte sitting in the RX FIFO.
        send_rx(8'($urandom_range(0, 255)), 1'b0, 1'b1, 64);
        check_eq("prereset_rx_has_data", rx_empty, 1'b0);
        push_tx(8'hC3);
        wait_fall(500, ok);
        check_eq("midtx_started", ok, 1'b1);
        repeat (200) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("midrst_uart_tx", uart_tx, 1'b1);
        check_eq("midrst_rx_empty", rx_empty, 1'b1);
        check_eq("midrst_tx_full", tx_full, 1'b0);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        repeat (1000) @(negedge sys_clk);
        check_eq("postrst_tx_idle", uart_tx, 1'b1);
        check_eq("postrst_rx_empty", rx_empty, 1'b0 ^ 1'b1);

        // Runtime divisor 2 gives 32-cycle bits.
        set_div(16'd2);
        push_tx(8'h5A);
        check_tx_frame("div2", 8'h5A, 32);
        repeat (64) @(negedge sys_clk);

        // After reset the start bit lasts the default bit period.
        @(negedge sys_clk) sys_rst_n = 1'b0;
        @(negedge sys_clk) sys_rst_n = 1'b1;
        push_tx(8'h01);
        wait_fall(3000, ok);
        check_eq("dflt_start_seen", ok, 1'b1);
        cnt = 1;
        for (int c = 0; c < 2000 && uart_tx == 1'b0; c++) begin
            @(negedge sys_clk);
            if (uart_tx == 1'b0) cnt++;
        end
        check_eq("dflt_bit_period", cnt, (CLK_FREQ / BAUD / 16) * 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
